// File: rtl/nes_cpu_bus_master.sv
// CPU-side initiator for the cartridge mapper bus: queued PRG reads/writes, each aligned to M2 (ce).
// Optional macro BUS_MASTER_OPENBUS_TRACK_EN makes unclaimed reads return the last value seen on the bus.
module nes_cpu_bus_master #(
  parameter int         FIFO_DEPTH       = 4,
  parameter logic [7:0] OPEN_BUS_DEFAULT = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic [15:0] prg_ain,
  output logic [7:0]  prg_din,
  output logic        prg_read,
  output logic        prg_write,
  input  logic [7:0]  prg_dout,
  input  logic [15:0] flags_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_RESP} state_t;
  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;

  cmd_t          fifo_q [FIFO_DEPTH];
  cmd_t          fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          cmd_ready_q, cmd_ready_d;
  state_t        state_q, state_d;
  logic          cur_write_q, cur_write_d;
  logic [15:0]   prg_ain_q, prg_ain_d;
  logic [7:0]    prg_din_q, prg_din_d;
  logic          prg_read_q, prg_read_d;
  logic          prg_write_q, prg_write_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;

  logic       push, pop, sample;
  logic [7:0] open_bus, rd_data;
  logic       unused_flags;

  assign push    = cmd_valid && cmd_ready_q;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  assign sample  = (state_q == S_STROBE) && ce;
  assign rd_data = flags_out[1] ? prg_dout : open_bus;
  assign unused_flags = ^{flags_out[15:2], flags_out[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      state_q     <= S_IDLE;
      cur_write_q <= 1'b0;
      prg_ain_q   <= 16'h0000;
      prg_din_q   <= 8'h00;
      prg_read_q  <= 1'b0;
      prg_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      state_q     <= state_d;
      cur_write_q <= cur_write_d;
      prg_ain_q   <= prg_ain_d;
      prg_din_q   <= prg_din_d;
      prg_read_q  <= prg_read_d;
      prg_write_q <= prg_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // First ce in SETUP only arms the strobe; the second ce (in STROBE) is the one the mapper samples.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (count_q != '0) state_d = S_SETUP;
      S_SETUP:  if (ce) state_d = S_STROBE;
      S_STROBE: if (ce) state_d = cur_write_q ? S_IDLE : S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cur_write_d = cur_write_q;
    prg_ain_d   = prg_ain_q;
    prg_din_d   = prg_din_q;
    prg_read_d  = prg_read_q;
    prg_write_d = prg_write_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    if (push) begin
      fifo_d[wr_ptr_q] = '{write: cmd_write, addr: cmd_addr, data: cmd_data};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    count_d     = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    cmd_ready_d = (count_d != DEPTH_C);

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cur_write_d = fifo_q[rd_ptr_q].write;
          prg_ain_d   = fifo_q[rd_ptr_q].addr;
          prg_din_d   = fifo_q[rd_ptr_q].data;
        end
      end
      S_SETUP: begin
        if (ce) begin
          prg_write_d = cur_write_q;
          prg_read_d  = !cur_write_q;
        end
      end
      S_STROBE: begin
        if (ce) begin
          prg_write_d = 1'b0;
          prg_read_d  = 1'b0;
          if (!cur_write_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_data;
          end
        end
      end
      S_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

`ifdef BUS_MASTER_OPENBUS_TRACK_EN
  logic [7:0] open_bus_q, open_bus_d;

  always_ff @(posedge clk) begin
    if (reset) open_bus_q <= OPEN_BUS_DEFAULT;
    else       open_bus_q <= open_bus_d;
  end

  always_comb begin
    open_bus_d = open_bus_q;
    if (sample) open_bus_d = cur_write_q ? prg_din_q : rd_data;
  end

  assign open_bus = open_bus_q;
`else
  assign open_bus = OPEN_BUS_DEFAULT;
`endif

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (count_q != '0) || (state_q != S_IDLE);
  assign prg_ain   = prg_ain_q;
  assign prg_din   = prg_din_q;
  assign prg_read  = prg_read_q;
  assign prg_write = prg_write_q;
endmodule
